// File: rtl/seg_pkg.sv
// seg_pkg: shared encodings for the seven-segment scan controller
package seg_pkg;
    typedef enum logic [1:0] {WIN0 = 2'b00, WIN1 = 2'b01, WIN2 = 2'b10} win_t;
    typedef enum logic [1:0] {SLOT0 = 2'd0, SLOT1 = 2'd1, SLOT2 = 2'd2, SLOT3 = 2'd3} slot_t;
    localparam logic [3:0] ANODE_OFF   = 4'b1111;
    localparam logic [3:0] DIGIT_MINUS = 4'hA;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    // Active-low anode pattern for a slot; slot 0 is the rightmost anode.
    function automatic logic [3:0] anode_of(slot_t s);
        return ~(4'b0001 << s);
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces one raw button, emitting a one-cycle press pulse.
// Ports: clk, rst (sync, active-high), btn (raw async input), press (1-cycle pulse on accepted 0->1).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (sync[1] != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            cnt   <= (sync[1] == stable || accept) ? '0 : cnt + CW'(1);
            press <= accept && sync[1];
            if (accept)
                stable <= sync[1];
        end
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scrolls a 3-digit window over a 5-digit BCD value and scans it plus a sign slot onto 4 anodes.
// Ports: clk, rst (sync, active-high), bcd[19:0], sign, btn_l, btn_r (raw buttons),
//        anode[3:0] (active-low), digit[3:0], digit_is_sign, window[1:0].
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] bcd,
    input  logic        sign,
    input  logic        btn_l,
    input  logic        btn_r,
    output logic [3:0]  anode,
    output logic [3:0]  digit,
    output logic        digit_is_sign,
    output logic [1:0]  window
);
    localparam int RW = $clog2(REFRESH_DIV);
    win_t          win, win_next;
    slot_t         slot;
    logic [RW-1:0] ref_cnt;
    logic          press_l, press_r;
    logic [2:0]    idx;
    logic [31:0]   bcd_ext;
    logic [3:0]    digit_next;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (.clk(clk), .rst(rst), .btn(btn_l), .press(press_l));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (.clk(clk), .rst(rst), .btn(btn_r), .press(press_r));

    always_ff @(posedge clk) begin
        if (rst)
            win <= WIN0;
        else
            win <= win_next;
    end

    // Simultaneous presses cancel; both directions saturate at the ends.
    always_comb begin
        win_next = (press_l && !press_r) ? (win == WIN0 ? WIN1 : WIN2) :
                   (press_r && !press_l) ? (win == WIN2 ? WIN1 : WIN0) : win;
    end

    always_comb begin
        window = win;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
            slot    <= SLOT0;
        end else if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            slot    <= slot_t'(slot + 2'd1);
        end else begin
            ref_cnt <= ref_cnt + RW'(1);
        end
    end

    // Nibble index = offset + slot; padding keeps the slot-3 index in range although it is never selected.
    assign idx     = {1'b0, win} + {1'b0, slot};
    assign bcd_ext = {12'hFFF, bcd};

    always_comb begin
        digit_next = (slot == SLOT3) ? (sign ? DIGIT_MINUS : DIGIT_BLANK) : bcd_ext[{idx, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anode         <= ANODE_OFF;
            digit         <= DIGIT_BLANK;
            digit_is_sign <= 1'b0;
        end else begin
            anode         <= anode_of(slot);
            digit         <= digit_next;
            digit_is_sign <= (slot == SLOT3);
        end
    end
endmodule
